// File: rtl/uart_tx_frame_ctrl_pkg.sv
// uart_tx_pkg: state encoding, frame-format constants and DATA_W range check
// shared by the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STOP_1   = 1'b0;
    localparam logic STOP_2   = 1'b1;

    function automatic bit data_w_legal(input int w);
        return w >= 5 && w <= 9;
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: word handshake plus per-frame format from the TX data source.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              par_en;
    logic              par_odd;
    logic              stop2;

    modport master (output data_in, data_valid, par_en, par_odd, stop2, input data_ready);
    modport slave  (input data_in, data_valid, par_en, par_odd, stop2, output data_ready);
endinterface

// File: rtl/uart_tx_frame_ctrl_shift.sv
// uart_tx_shift: LSB-first data shift register and data-bit counter for one frame.
module uart_tx_shift #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              count,
    input  logic [DATA_W-1:0] din,
    output logic              lsb,
    output logic              last_bit
);
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Only DATA-state shifts are counted, so the count peaks at DATA_W-1 and fits CNT_W.
    always_comb begin
        shreg_d = load ? din : shift ? shreg_q >> 1 : shreg_q;
        cnt_d   = load ? '0 : count ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lsb      = shreg_q[0];
    assign last_bit = cnt_q == CNT_W'(DATA_W - 1);
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART transmit frame FSM with runtime parity/stop format,
// baud-tick pacing and valid/ready word intake; drives the serial line directly.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_tick,
    uart_tx_frame_ctrl_if.slave  s,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);
    state_t state_q, state_d;
    logic   tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic   par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
    logic   last_stop, accept, shift, count, lsb, last_bit;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("uart_tx_frame_ctrl: DATA_W must be in 5..9");
    end

    uart_tx_shift #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (shift),
        .count   (count),
        .din     (s.data_in),
        .lsb     (lsb),
        .last_bit(last_bit)
    );

    assign last_stop    = stop2_q == STOP_1 || stop_cnt_q;
    assign s.data_ready = bit_tick && (state_q == IDLE || (state_q == STOP && last_stop));
    assign accept       = s.data_valid && s.data_ready;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        par_d      = par_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        shift      = 1'b0;
        count      = 1'b0;
        if (bit_tick) begin
            case (state_q)
                IDLE: tx_d = 1'b1;
                START: begin
                    tx_d    = lsb;
                    shift   = 1'b1;
                    state_d = DATA;
                end
                DATA: begin
                    if (!last_bit) begin
                        tx_d  = lsb;
                        shift = 1'b1;
                        count = 1'b1;
                    end else begin
                        tx_d       = par_en_q ? par_q : 1'b1;
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
                PARITY: begin
                    tx_d       = 1'b1;
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (!last_stop) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
            // A word taken on the last stop tick starts the next frame with no idle gap.
            if (accept) begin
                par_en_d   = s.par_en;
                par_d      = ^s.data_in ^ (s.par_odd == PAR_ODD);
                stop2_d    = s.stop2;
                stop_cnt_d = 1'b0;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                state_d    = START;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed and randomized frames checked against a queue-of-line-bits
// reference model; the model tracks what the serial line must show after every tick.
module tb_uart_tx_frame_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         pe;
        logic         po;
        logic         s2;
    } word_t;
    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_tick = 1'b0;
    logic tx_out, busy, frame_done;

    int total = 0;
    int bad = 0;
    int tick_div = 1;
    int tick_ctr = 0;
    int done_cnt = 0;
    bit line[$];
    word_t src[$];
    logic [15:0] hist = '1;

    uart_tx_frame_ctrl_if #(.DATA_W(W)) bus ();

    uart_tx_frame_ctrl #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_tick  (bit_tick),
        .s         (bus.slave),
        .tx_out    (tx_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Line values in order: start, data LSB first, optional parity, one or two stops.
    function automatic bq_t frame_bits(input word_t w);
        bq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(w.d[i]);
        if (w.pe) q.push_back((^w.d) ^ w.po);
        q.push_back(1'b1);
        if (w.s2) q.push_back(1'b1);
        return q;
    endfunction

    function automatic word_t mk(input logic [W-1:0] d, input logic pe, input logic po, input logic s2);
        return word_t'{d, pe, po, s2};
    endfunction

    // One clock: drive at negedge, check ready before the edge and line state after it.
    task automatic step();
        bit rdy, acc, done;
        bit_tick = (tick_ctr % tick_div) == 0;
        tick_ctr++;
        if (src.size() > 0) begin
            bus.data_valid = 1'b1;
            bus.data_in    = src[0].d;
            bus.par_en     = src[0].pe;
            bus.par_odd    = src[0].po;
            bus.stop2      = src[0].s2;
        end else begin
            bus.data_valid = 1'b0;
            bus.data_in    = W'($urandom);
            bus.par_en     = 1'($urandom);
            bus.par_odd    = 1'($urandom);
            bus.stop2      = 1'($urandom);
        end
        #1;
        rdy = bit_tick && line.size() <= 1;
        chk("data_ready", 32'(bus.data_ready), 32'(rdy));
        acc = bus.data_valid && rdy;
        @(posedge clk);
        #1;
        done = 1'b0;
        if (bit_tick) begin
            if (line.size() > 0) begin
                void'(line.pop_front());
                done = line.size() == 0;
            end
            if (acc) line = frame_bits(src.pop_front());
            hist = {hist[14:0], tx_out};
        end
        if (frame_done === 1'b1) done_cnt++;
        chk("tx_out", 32'(tx_out), 32'(line.size() > 0 ? line[0] : 1'b1));
        chk("busy", 32'(busy), 32'(line.size() > 0));
        chk("frame_done", 32'(frame_done), 32'(done));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((line.size() > 0 || src.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.par_en     = 1'b0;
        bus.par_odd    = 1'b0;
        bus.stop2      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(bus.data_ready), 32'd0);
        rst = 1'b0;

        // Plain 8N1 frame, tick every cycle.
        src.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
        drain();
        chk("t1_seq", 32'(hist[10:0]), 32'(11'b01010010111));

        // Even then odd parity with two stop bits.
        src.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b1));
        drain();
        chk("t2_even_seq", 32'(hist[12:0]), 32'(13'b0101001010111));
        src.push_back(mk(8'hA5, 1'b1, 1'b1, 1'b1));
        drain();
        chk("t2_odd_seq", 32'(hist[12:0]), 32'(13'b0101001011111));

        // Back-to-back words with valid held.
        d0 = done_cnt;
        src.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0));
        src.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0));
        drain();
        chk("t3_done_pulses", 32'(done_cnt - d0), 32'd2);

        // Slow baud: valid rises between ticks.
        tick_div = 4;
        tick_ctr = 1;
        src.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        drain();
        repeat (3) step();

        // Reset during data bit 3, then a clean frame.
        tick_div = 1;
        tick_ctr = 0;
        d0 = done_cnt;
        src.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (line.size() != 6 && n < 50) begin
            step();
            n++;
        end
        chk("t5_reach_bit3", 32'(line.size()), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(tx_out), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(frame_done), 32'd0);
        line.delete();
        src.delete();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        src.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        drain();

        // Next word's format is on the bus during the current frame.
        src.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
        src.push_back(mk(8'h96, 1'b1, 1'b1, 1'b1));
        src.push_back(mk(8'h5A, 1'b0, 1'b1, 1'b0));
        drain();

        for (int k = 0; k < 30; k++) begin
            tick_div = $urandom_range(1, 3);
            repeat ($urandom_range(1, 2))
                src.push_back(mk(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
            drain();
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
